conv_frame_encoder: RTL and testbench

//  Upstream channel-encoder stage for the 7-bit-frame Viterbi decoder (rate 1/2, K=3, generators 7/5 octal).

---
 rtl/conv_frame_encoder.sv | 116 +++++++++++
 tb/tb_conv_frame_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 K=3 (7/5) convolutional frame encoder, double-buffered collect/tx.
// Optional CONV_ENC_ERR_INJ_EN adds an err_inj port that flips single coded bits.
module conv_frame_encoder #(
  parameter int DATA_BITS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  output logic frame_start,
  output logic frame_idle
`ifdef CONV_ENC_ERR_INJ_EN
  ,
  input  logic err_inj
`endif
);

  localparam int FRAME_LEN = 2 * (DATA_BITS + 2);
  localparam int SW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(DATA_BITS + 1);

  logic [SW-1:0] step;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] col;
  logic [DATA_BITS-1:0] tx;
  logic s1;
  logic s0;

  logic at0;
  logic last;
  logic full;
  logic accept;
  logic odd;
  logic u;
  logic s1e;
  logic s0e;
  logic coded;
  logic flip;
  logic [SW-2:0] k;
  logic [DATA_BITS-1:0] txc;
  logic [DATA_BITS+1:0] pay;

  assign at0 = (step == '0);
  assign last = (step == SW'(FRAME_LEN - 1));
  assign full = (cnt == CW'(DATA_BITS));
  assign din_ready = dout_valid && (cnt < CW'(DATA_BITS));
  assign accept = din_valid && din_ready;

`ifdef CONV_ENC_ERR_INJ_EN
  assign flip = err_inj;
`else
  assign flip = 1'b0;
`endif

  // Coded bit for the current step; at step 0 the tx payload is the
  // freshly latched frame (or zeros for an idle frame) and state is 00.
  always_comb begin
    txc = tx;
    if (at0) begin
      txc = full ? col : '0;
    end
    pay = {2'b00, txc};
    k = step[SW-1:1];
    odd = step[0];
    u = pay[k];
    s1e = at0 ? 1'b0 : s1;
    s0e = at0 ? 1'b0 : s0;
    coded = odd ? (u ^ s0e) : (u ^ s1e ^ s0e);
  end

  // Step counter, registered outputs, encoder state and buffers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step <= '0;
      cnt <= '0;
      col <= '0;
      tx <= '0;
      s1 <= 1'b0;
      s0 <= 1'b0;
      dout <= 1'b0;
      dout_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_idle <= 1'b0;
    end else begin
      dout_valid <= 1'b1;
      dout <= coded ^ flip;
      frame_start <= at0;
      step <= last ? '0 : step + 1'b1;
      if (at0) begin
        tx <= txc;
        frame_idle <= !full;
      end
      if (odd) begin
        s1 <= u;
        s0 <= s1;
      end else if (at0) begin
        s1 <= 1'b0;
        s0 <= 1'b0;
      end
      if (at0 && full) begin
        cnt <= '0;
      end else if (accept) begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (cnt == CW'(i)) begin
            col[i] <= din;
          end
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder.
// Define CONV_ENC_ERR_INJ_EN to also exercise err_inj.
module tb_conv_frame_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic err_inj = 1'b0;
  logic din_ready;
  logic dout;
  logic dout_valid;
  logic frame_start;
  logic frame_idle;

  int checks = 0;
  int failures = 0;

  localparam logic [13:0] C10110 = 14'b11100001011100;
  localparam logic [13:0] C11111 = 14'b11011010100111;
  localparam logic [13:0] CINJ = 14'b11000001011100;

  always #5 clk = ~clk;

  conv_frame_encoder #(.DATA_BITS(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .frame_start(frame_start),
    .frame_idle(frame_idle)
`ifdef CONV_ENC_ERR_INJ_EN
    ,
    .err_inj(err_inj)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [4:0] p);
    for (int i = 4; i >= 0; i--) begin
      din = p[i];
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    din = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    chk({tag, "_fs_timeout"}, frame_start, 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic [13:0] exp,
                             input logic idle, input int inj,
                             input logic rdy);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s_dout%0d", tag, i), dout, exp[13-i]);
      chk($sformatf("%s_idle%0d", tag, i), frame_idle, idle);
      chk($sformatf("%s_vld%0d", tag, i), dout_valid, 1'b1);
      chk($sformatf("%s_fs%0d", tag, i), frame_start, i == 0);
      if (rdy) begin
        chk($sformatf("%s_rdy%0d", tag, i), din_ready, 1'b1);
      end
      err_inj = (i + 1 == inj);
      @(negedge clk);
    end
    err_inj = 1'b0;
  endtask

  initial begin
    logic [4:0] pl [4];
    logic [13:0] cd [4];
    int st;
    int f;
    pl[0] = 5'b10110;
    pl[1] = 5'b11111;
    pl[2] = 5'b10110;
    pl[3] = 5'b11111;
    cd[0] = C10110;
    cd[1] = C11111;
    cd[2] = C10110;
    cd[3] = C11111;

    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 1'b0);
    chk("rst_vld", dout_valid, 1'b0);
    chk("rst_rdy", din_ready, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_idle", frame_idle, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_fs", frame_start, 1'b1);
    chk("first_idle", frame_idle, 1'b1);
    chk("first_vld", dout_valid, 1'b1);
    chk("first_rdy", din_ready, 1'b1);
    chk("first_dout", dout, 1'b0);

    feed(5'b10110);
    wait_fs("t2");
    check_frame("t2", C10110, 1'b0, -1, 1'b0);

    feed(5'b11111);
    wait_fs("t3");
    check_frame("t3", C11111, 1'b0, -1, 1'b0);

    din = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    din = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_fs("t4a");
    check_frame("t4idle", 14'd0, 1'b1, -1, 1'b1);
    din = 1'b1;
    din_valid = 1'b1;
    @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    wait_fs("t4b");
    check_frame("t4data", C10110, 1'b0, -1, 1'b0);

    for (int cyc = 0; cyc < 56; cyc++) begin
      st = cyc % 14;
      f = cyc / 14;
      chk($sformatf("t5_rdy%0d", cyc), din_ready, st < 5);
      if (f >= 1) begin
        chk($sformatf("t5_dout%0d", cyc), dout, cd[f-1][13-st]);
        chk($sformatf("t5_idle%0d", cyc), frame_idle, 1'b0);
      end
      din_valid = 1'b1;
      din = (st < 5) ? pl[f][4-st] : 1'b0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    din = 1'b0;

    feed(5'b11111);
    wait_fs("t6");
    feed(5'b10110);
    repeat (2) @(negedge clk);
    chk("t6_s7_dout", dout, C11111[13-7]);
    chk("t6_s7_idle", frame_idle, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_dout", dout, 1'b0);
    chk("t6_rst_vld", dout_valid, 1'b0);
    chk("t6_rst_fs", frame_start, 1'b0);
    chk("t6_rst_idle", frame_idle, 1'b0);
    chk("t6_rst_rdy", din_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_frame("t6idle1", 14'd0, 1'b1, -1, 1'b1);
    check_frame("t6idle2", 14'd0, 1'b1, -1, 1'b1);

`ifdef CONV_ENC_ERR_INJ_EN
    feed(5'b10110);
    wait_fs("t7");
    check_frame("t7", CINJ, 1'b0, 2, 1'b0);
    feed(5'b10110);
    wait_fs("t7b");
    check_frame("t7clean", C10110, 1'b0, -1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
